// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: issues in-order imem requests from the PC register,
// pairs responses with their PCs and hands {pc, instr} to decode.
module ifetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] pc_cur,
    output logic        pc_load,
    output logic [31:0] pc_in,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   qcount_q, qcount_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [31:0]     tag_mem_q [DEPTH];
    logic [31:0]     qpc_q     [DEPTH];
    logic [31:0]     qinstr_q  [DEPTH];

    logic [CW:0]     inuse;
    logic            credit;
    logic            fire;
    logic            rsp_take;
    logic            rsp_keep;
    logic            pop;

    assign inuse  = {1'b0, outstanding_q} + {1'b0, qcount_q};
    assign credit = (inuse < DEPTH_C);

    assign imem_req_valid = !rst && fetch_en && (state_q == RUN) && credit && !redirect_valid;
    assign imem_req_addr  = pc_cur;
    assign fire           = imem_req_valid && imem_req_ready;
    assign pc_load        = !fire || redirect_valid;
    assign pc_in          = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_cur;

    assign id_valid = !rst && (qcount_q != '0);
    assign id_pc    = qpc_q[q_rd_q];
    assign id_instr = qinstr_q[q_rd_q];
    assign pop      = id_valid && id_ready;

    // Responses during FLUSH or coincident with a redirect are stale and only retire a slot.
    assign rsp_take = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep = rsp_take && (state_q == RUN) && !redirect_valid;

    always_comb begin
        outstanding_d = outstanding_q + CW'(fire) - CW'(rsp_take);
        state_d       = state_q;
        qcount_d      = qcount_q + CW'(rsp_keep) - CW'(pop);
        tag_wr_d      = tag_wr_q + PW'(fire);
        tag_rd_d      = tag_rd_q + PW'(rsp_keep);
        q_wr_d        = q_wr_q + PW'(rsp_keep);
        q_rd_d        = q_rd_q + PW'(pop);
        if (redirect_valid) begin
            qcount_d = '0;
            tag_wr_d = '0;
            tag_rd_d = '0;
            q_wr_d   = '0;
            q_rd_d   = '0;
        end
        case (state_q)
            RUN:     if (redirect_valid && (outstanding_d != '0)) state_d = FLUSH;
            FLUSH:   if (outstanding_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            outstanding_q <= '0;
            qcount_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            qcount_q      <= qcount_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
            if (fire) begin
                tag_mem_q[tag_wr_q] <= pc_cur;
            end
            if (rsp_keep) begin
                qpc_q[q_wr_q]    <= tag_mem_q[tag_rd_q];
                qinstr_q[q_wr_q] <= imem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC register and in-order memory environment, transaction-level
// reference model, a table of single-cycle vectors, directed corner sequences, random run.
module tb_ifetch_unit;
    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_cur(pc_cur),
        .pc_load(pc_load), .pc_in(pc_in),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Environment: PC register and memory with per-request latency.
    logic [31:0]  pc_next;
    logic [31:0]  mem_addr[$];
    int unsigned  mem_due[$];
    int unsigned  cyc = 0;
    int unsigned  mem_lat = 1;
    bit           rand_lat = 0;

    // Reference model: in-flight request PCs tagged with a redirect epoch, delivery queue.
    typedef struct packed {
        logic [31:0] pc;
        int unsigned ep;
    } infl_t;
    infl_t        inflight[$];
    logic [31:0]  expq[$];
    logic [31:0]  m_pc;
    int unsigned  epoch;

    logic [31:0]  dlv[$];
    logic         s_rv, s_pl, s_idv;
    logic [31:0]  s_pi, s_addr, s_idpc;

    typedef struct {
        bit          r, fe, rdy, redir;
        logic [31:0] rpc;
        bit          exp_rv, exp_pl, exp_idv;
        logic [31:0] exp_pi;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit fe, input bit rdy, input bit redir,
                        input logic [31:0] rpc, input bit idr);
        int unsigned stale;
        bit          rv_exp;
        @(posedge clk);
        #1;
        cyc++;
        pc_cur = pc_next;
        if (r) begin
            mem_addr.delete();
            mem_due.delete();
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr[0]);
        end
        rst = r; fetch_en = fe; imem_req_ready = rdy;
        redirect_valid = redir; redirect_pc = rpc; id_ready = idr;
        #7;
        s_rv = imem_req_valid; s_pl = pc_load; s_pi = pc_in; s_addr = imem_req_addr;
        s_idv = id_valid; s_idpc = id_pc;
        if (id_valid && idr) dlv.push_back(id_pc);
        if (imem_rsp_valid) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (imem_req_valid && rdy) begin
            mem_addr.push_back(imem_req_addr);
            mem_due.push_back(cyc + (rand_lat ? $urandom_range(1, 3) : mem_lat));
        end
        pc_next = r ? 32'h1000 : (pc_load ? pc_in : pc_cur + 32'd4);

        if (r) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_id_valid", id_valid, 0);
            inflight.delete();
            expq.delete();
            m_pc  = 32'h1000;
            epoch = 0;
        end else begin
            stale = 0;
            foreach (inflight[i]) if (inflight[i].ep != epoch) stale++;
            rv_exp = fe && !redir && stale == 0 && (inflight.size() + expq.size() < DEPTH);
            chk("req_valid", imem_req_valid, rv_exp);
            if (rv_exp) chk("req_addr", imem_req_addr, m_pc);
            chk("pc_load", pc_load, !(rv_exp && rdy) || redir);
            chk("pc_in", pc_in, redir ? (rpc & 32'hFFFF_FFFC) : pc_cur);
            chk("id_valid", id_valid, expq.size() > 0);
            if (expq.size() > 0) begin
                chk("id_pc", id_pc, expq[0]);
                chk("id_instr", id_instr, mem_word(expq[0]));
                if (idr) void'(expq.pop_front());
            end
            if (imem_rsp_valid && inflight.size() > 0) begin
                if (inflight[0].ep == epoch && !redir) expq.push_back(inflight[0].pc);
                void'(inflight.pop_front());
            end
            if (redir) begin
                epoch++;
                expq.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end
            if (rv_exp && rdy) begin
                inflight.push_back('{pc: m_pc, ep: epoch});
                m_pc += 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, 0);
        dlv.delete();
    endtask

    task automatic run(input int unsigned n, input bit fe, input bit rdy, input bit idr);
        for (int unsigned i = 0; i < n; i++) step(0, fe, rdy, 0, '0, idr);
    endtask

    task automatic wait_dlv(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget && dlv.size() < n; i++) step(0, 1, 1, 0, '0, 1);
        if (dlv.size() < n) chk("dlv_timeout", dlv.size(), n);
    endtask

    initial begin
        rst = 1; fetch_en = 0; imem_req_ready = 0; redirect_valid = 0; redirect_pc = '0;
        id_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        pc_cur = 32'h1000; pc_next = 32'h1000; m_pc = 32'h1000; epoch = 0;

        // Single-cycle vectors applied from the idle post-reset state (pc_cur = 0x1000).
        vecs[0] = '{r:0, fe:0, rdy:1, redir:0, rpc:32'h0,         exp_rv:0, exp_pl:1, exp_idv:0, exp_pi:32'h1000};
        vecs[1] = '{r:0, fe:1, rdy:0, redir:0, rpc:32'h0,         exp_rv:1, exp_pl:1, exp_idv:0, exp_pi:32'h1000};
        vecs[2] = '{r:0, fe:1, rdy:1, redir:0, rpc:32'h0,         exp_rv:1, exp_pl:0, exp_idv:0, exp_pi:32'h1000};
        vecs[3] = '{r:0, fe:1, rdy:1, redir:1, rpc:32'h2002,      exp_rv:0, exp_pl:1, exp_idv:0, exp_pi:32'h2000};
        vecs[4] = '{r:0, fe:0, rdy:0, redir:1, rpc:32'h3003,      exp_rv:0, exp_pl:1, exp_idv:0, exp_pi:32'h3000};
        vecs[5] = '{r:0, fe:1, rdy:0, redir:1, rpc:32'hFFFF_FFFF, exp_rv:0, exp_pl:1, exp_idv:0, exp_pi:32'hFFFF_FFFC};
        vecs[6] = '{r:1, fe:1, rdy:1, redir:0, rpc:32'h0,         exp_rv:0, exp_pl:1, exp_idv:0, exp_pi:32'h1000};
        mem_lat = 1;
        do_reset();
        foreach (vecs[i]) begin
            do_reset();
            step(vecs[i].r, vecs[i].fe, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, 1);
            chk("vec_req_valid", s_rv, vecs[i].exp_rv);
            chk("vec_pc_load", s_pl, vecs[i].exp_pl);
            chk("vec_pc_in", s_pi, vecs[i].exp_pi);
            chk("vec_id_valid", s_idv, vecs[i].exp_idv);
        end

        // Sequential fetch from reset.
        mem_lat = 1;
        do_reset();
        wait_dlv(6, 40);
        for (int unsigned i = 0; i < 6 && i < dlv.size(); i++)
            chk("seq_pc", dlv[i], 32'h1000 + 4 * i);

        // Memory back-pressure at 0x1008 holds the PC.
        do_reset();
        for (int unsigned i = 0; i < 20 && m_pc != 32'h1008; i++) step(0, 1, 1, 0, '0, 1);
        for (int unsigned i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, '0, 1);
            chk("stall_pc_load", s_pl, 1);
            chk("stall_pc_in", s_pi, 32'h1008);
        end
        step(0, 1, 1, 0, '0, 1);
        chk("resume_req_valid", s_rv, 1);
        chk("resume_addr", s_addr, 32'h1008);
        wait_dlv(3, 30);
        if (dlv.size() >= 3) chk("resume_dlv", dlv[2], 32'h1008);

        // Decode back-pressure fills the queue; release delivers in order.
        do_reset();
        run(4, 1, 1, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, '0, 0);
            chk("full_id_valid", s_idv, 1);
            chk("full_head_pc", s_idpc, 32'h1000);
            chk("full_req_valid", s_rv, 0);
        end
        wait_dlv(5, 40);
        for (int unsigned i = 0; i < 5 && i < dlv.size(); i++)
            chk("release_pc", dlv[i], 32'h1000 + 4 * i);

        // Redirect with two requests outstanding: both responses dropped.
        mem_lat = 4;
        do_reset();
        run(2, 1, 1, 1);
        step(0, 1, 1, 1, 32'h2002, 1);
        chk("redir_pc_in", s_pi, 32'h2000);
        chk("redir_pc_load", s_pl, 1);
        chk("redir_req_valid", s_rv, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, '0, 1);
            chk("flush_req_valid", s_rv, 0);
        end
        wait_dlv(1, 30);
        if (dlv.size() >= 1) chk("flush_first_pc", dlv[0], 32'h2000);

        // Redirect coincident with a response and an id pop.
        mem_lat = 1;
        do_reset();
        run(2, 1, 1, 0);
        step(0, 1, 1, 1, 32'h3000, 1);
        chk("coinc_pop_valid", s_idv, 1);
        wait_dlv(2, 30);
        if (dlv.size() >= 2) begin
            chk("coinc_pop_pc", dlv[0], 32'h1000);
            chk("coinc_next_pc", dlv[1], 32'h3000);
        end

        // Reset with a full queue.
        do_reset();
        run(6, 1, 1, 0);
        step(1, 1, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 1);
        chk("post_rst_id_valid", s_idv, 0);
        chk("post_rst_req_valid", s_rv, 0);
        dlv.delete();
        step(0, 1, 1, 0, '0, 1);
        chk("restart_req_valid", s_rv, 1);
        chk("restart_addr", s_addr, 32'h1000);
        wait_dlv(1, 20);
        if (dlv.size() >= 1) chk("restart_dlv", dlv[0], 32'h1000);

        // Randomized traffic against the model.
        rand_lat = 1;
        do_reset();
        for (int unsigned i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
